// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA colour-code loader and its helpers.
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET0   = 3'd1,
    ST_GET1   = 3'd2,
    ST_GET2   = 3'd3,
    ST_GETCHK = 3'd4
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
  localparam logic [23:0] RESET_CODE_DEF = 24'hF0000F;

  // RGB444 halves of the 24-bit colour code
  localparam int LEFT_HI  = 23;
  localparam int LEFT_LO  = 12;
  localparam int RIGHT_HI = 11;
  localparam int RIGHT_LO = 0;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/vga_color_loader_edge.sv
// Rising-edge detector: registers the input and pulses for one cycle when it
// goes from low to high. RST_VAL chooses what the input is assumed to be at reset.
module edge_detect_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= RST_VAL;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/vga_color_loader.sv
// Assembles framed serial bytes into a 24-bit colour code and commits it to
// the VGA block only on a vsync rising edge, so colour changes never tear.
module vga_color_loader
  import vga_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int          TIMEOUT    = 50000,
  parameter int          TO_W       = 16,
  parameter logic [23:0] RESET_CODE = RESET_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        vsync,
  output logic [23:0] code,
  output logic        pending,
  output logic        pkt_ok,
  output logic        pkt_err
);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [23:0]       pend_code_q, pend_code_d;
  logic [23:0]       code_q, code_d;
  logic              pending_q, pending_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              pkt_err_q, pkt_err_d;
  logic              pend_set;
  logic              vsync_rise;

  // vsync assumed high at reset so a vsync already high at release is not an edge
  edge_detect_rise #(.RST_VAL(1'b1)) u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (vsync),
    .rise_o (vsync_rise)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    pend_code_d = pend_code_q;
    code_d      = code_q;
    pending_d   = pending_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    pend_set    = 1'b0;

    unique case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_GET0;
      ST_GET0: if (rx_valid) begin d0_d = rx_data; state_d = ST_GET1; end
      ST_GET1: if (rx_valid) begin d1_d = rx_data; state_d = ST_GET2; end
      ST_GET2: if (rx_valid) begin d2_d = rx_data; state_d = ST_GETCHK; end
      ST_GETCHK: if (rx_valid) begin
        if (rx_data == pkt_checksum(d0_q, d1_q, d2_q)) begin
          pend_code_d = {d0_q, d1_q, d2_q};
          pkt_ok_d    = 1'b1;
          pend_set    = 1'b1;
        end else begin
          pkt_err_d   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog: only runs while a packet is in flight
    if (state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (rx_valid) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
      to_cnt_d  = '0;
      state_d   = ST_IDLE;
      pkt_err_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // Commit the previously pending word; a same-cycle accept re-arms pending
    if (vsync_rise && pending_q) begin
      code_d    = pend_code_q;
      pending_d = 1'b0;
    end
    if (pend_set) pending_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      pend_code_q <= '0;
      code_q      <= RESET_CODE;
      pending_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      pend_code_q <= pend_code_d;
      code_q      <= code_d;
      pending_q   <= pending_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign code    = code_q;
  assign pending = pending_q;
  assign pkt_ok  = pkt_ok_q;
  assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_vga_color_loader.sv
// Directed bench for vga_color_loader: packet parsing, timeout, vsync commit,
// overwrite, same-cycle accept/commit and mid-packet reset.
module tb_vga_color_loader;

  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        vsync;
  logic [23:0] code;
  logic        pending;
  logic        pkt_ok;
  logic        pkt_err;

  int checks   = 0;
  int failures = 0;

  vga_color_loader #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT    (TIMEOUT),
    .TO_W       (16),
    .RESET_CODE (24'hF0000F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .vsync    (vsync),
    .code     (code),
    .pending  (pending),
    .pkt_ok   (pkt_ok),
    .pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] chk);
    send(8'hA5); send(b0); send(b1); send(b2); send(chk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    int n_err;
    int err_at;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; vsync = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();
    check("rst_code",    32'(code), 32'hF0000F);
    check("rst_pending", 32'(pending), 0);
    check("rst_pulses",  32'({pkt_ok, pkt_err}), 0);
    vsync = 1'b0;
    repeat (3) tick();
    check("rst_vsync_fall_code", 32'(code), 32'hF0000F);

    // Good packet, commit on vsync edge
    send_pkt(8'h12, 8'h34, 8'h56, 8'h70);
    check("p1_ok",      32'(pkt_ok), 1);
    check("p1_err",     32'(pkt_err), 0);
    check("p1_pending", 32'(pending), 1);
    check("p1_code",    32'(code), 32'hF0000F);
    tick();
    check("p1_ok_drop", 32'(pkt_ok), 0);
    vsync = 1'b1;
    tick();
    check("p1_commit_code", 32'(code), 32'h123456);
    check("p1_commit_pend", 32'(pending), 0);
    tick();
    vsync = 1'b0;
    tick();

    // Bad checksum
    send_pkt(8'h12, 8'h34, 8'h56, 8'h71);
    check("bad_err",     32'(pkt_err), 1);
    check("bad_ok",      32'(pkt_ok), 0);
    check("bad_pending", 32'(pending), 0);
    tick();
    check("bad_err_drop", 32'(pkt_err), 0);
    check("bad_code",     32'(code), 32'h123456);

    // Timeout after two bytes: pulse after exactly TIMEOUT idle cycles
    send(8'hA5);
    send(8'h12);
    n_err  = 0;
    err_at = 0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      tick();
      if (pkt_err) begin
        n_err++;
        err_at = k;
      end
    end
    check("to_pulses", 32'(n_err), 1);
    check("to_cycle",  32'(err_at), 32'(TIMEOUT));
    send_pkt(8'hAB, 8'hCD, 8'hEF, 8'h89);
    check("to_next_ok",   32'(pkt_ok), 1);
    check("to_next_pend", 32'(pending), 1);

    // Overwrite before vsync: last writer wins
    send_pkt(8'h12, 8'h34, 8'h56, 8'h70);
    send_pkt(8'hAB, 8'hCD, 8'hEF, 8'h89);
    check("ow_code_before", 32'(code), 32'h123456);
    vsync_pulse();
    check("ow_commit_code", 32'(code), 32'hABCDEF);
    check("ow_commit_pend", 32'(pending), 0);

    // Accept in the same cycle as the commit edge
    send_pkt(8'h44, 8'h55, 8'h66, 8'h77);
    send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
    rx_data = 8'h00; rx_valid = 1'b1; vsync = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("sim_code", 32'(code), 32'h445566);
    check("sim_pend", 32'(pending), 1);
    check("sim_ok",   32'(pkt_ok), 1);
    vsync = 1'b0;
    tick();
    vsync_pulse();
    check("sim_next_code", 32'(code), 32'h112233);
    check("sim_next_pend", 32'(pending), 0);

    // Stray bytes in IDLE
    send_pkt(8'h44, 8'h55, 8'h66, 8'h77);
    send(8'h00); check("stray00", 32'({pkt_ok, pkt_err}), 0);
    send(8'hFF); check("strayFF", 32'({pkt_ok, pkt_err}), 0);
    send(8'h5A); check("stray5A", 32'({pkt_ok, pkt_err}), 0);
    check("stray_pend", 32'(pending), 1);

    // Reset between D1 and D2
    send(8'hA5); send(8'h12); send(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_code",   32'(code), 32'hF0000F);
    check("mrst_pend",   32'(pending), 0);
    check("mrst_pulses", 32'({pkt_ok, pkt_err}), 0);
    send(8'h56); check("mrst_d2", 32'({pkt_ok, pkt_err}), 0);
    send(8'h70); check("mrst_chk", 32'({pkt_ok, pkt_err}), 0);
    tick();
    check("mrst_chk_late", 32'({pkt_ok, pkt_err, pending}), 0);
    vsync_pulse();
    check("mrst_vsync_code", 32'(code), 32'hF0000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
